// File: rtl/jsilicon_alu_exec_if.sv
// jsilicon_alu_exec_if: operand/opcode input and result output handshakes of the ALU execute stage
interface jsilicon_alu_exec_if #(parameter int TAG_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_res;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  modport master (output in_valid, in_op, in_a, in_b, in_tag, out_ready,
                  input  in_ready, out_valid, out_res, out_flags, out_tag);
  modport slave  (input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
                  output in_ready, out_valid, out_res, out_flags, out_tag);
endinterface

// File: rtl/jsilicon_alu_exec.sv
// jsilicon_alu_exec: ALU execute stage feeding a result FIFO; JSI_PERF_CNT_EN adds perf_ops/perf_err counters
module jsilicon_alu_exec #(
  parameter int RES_DEPTH = 2,
  parameter int TAG_W     = 4
) (
  input logic clk,
  input logic rst,
  jsilicon_alu_exec_if.slave bus
`ifdef JSI_PERF_CNT_EN
  ,
  output logic [15:0] perf_ops,
  output logic [7:0]  perf_err
`endif
);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;
  logic [8:0]  sum;
  logic [7:0]  minus, quot, rem;
  logic [15:0] multiply, res;
  logic        dbz, illegal, carry, push, pop;
  logic [3:0]  flags;
  logic [15:0]      res_mem_q [RES_DEPTH];
  logic [3:0]       flags_mem_q [RES_DEPTH];
  logic [TAG_W-1:0] tag_mem_q [RES_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sum      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    minus    = bus.in_a - bus.in_b;
    multiply = {8'h00, bus.in_a} * {8'h00, bus.in_b};
    illegal  = bus.in_op > 3'd4;
    dbz      = bus.in_op == 3'd3 && bus.in_b == 8'h00;
    quot     = dbz ? 8'h00 : bus.in_a / bus.in_b;
    rem      = dbz ? 8'h00 : bus.in_a % bus.in_b;
    res      = bus.in_op == 3'd0 ? {8'h00, sum[7:0]} :
               bus.in_op == 3'd1 ? {8'h00, minus} :
               bus.in_op == 3'd2 ? multiply :
               bus.in_op == 3'd3 ? {rem, quot} :
               bus.in_op == 3'd4 ? {8'h00, bus.in_a} : 16'h0000;
    carry    = bus.in_op == 3'd0 ? sum[8] :
               bus.in_op == 3'd1 ? bus.in_a < bus.in_b :
               bus.in_op == 3'd2 ? |multiply[15:8] : 1'b0;
    flags    = {illegal, dbz, carry, res == 16'h0000};
  end
  assign bus.in_ready  = cnt_q != CW'(RES_DEPTH);
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_res   = bus.out_valid ? res_mem_q[rd_ptr_q] : '0;
  assign bus.out_flags = bus.out_valid ? flags_mem_q[rd_ptr_q] : '0;
  assign bus.out_tag   = bus.out_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = push && !pop ? cnt_q + CW'(1) :
               !push && pop ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  // Storage needs no reset: the head is masked to zero whenever the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_ptr_q]   <= res;
      flags_mem_q[wr_ptr_q] <= flags;
      tag_mem_q[wr_ptr_q]   <= bus.in_tag;
    end
  end
`ifdef JSI_PERF_CNT_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [7:0]  perf_err_q, perf_err_d;
  always_comb begin
    perf_ops_d = push && perf_ops_q != '1 ? perf_ops_q + 16'd1 : perf_ops_q;
    perf_err_d = push && (dbz || illegal) && perf_err_q != '1 ? perf_err_q + 8'd1 : perf_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q <= '0;
      perf_err_q <= '0;
    end else begin
      perf_ops_q <= perf_ops_d;
      perf_err_q <= perf_err_d;
    end
  end
  assign perf_ops = perf_ops_q;
  assign perf_err = perf_err_q;
`endif
endmodule
